actor_token_fifo: RTL and testbench

ACTOR_TOKEN_FIFO -- requirements
Module: actor_token_fifo

---
 rtl/actor_token_fifo_pkg.sv | 28 ++
 rtl/actor_token_fifo_ram.sv | 39 +++
 rtl/actor_token_fifo.sv | 162 ++++++++++++++++
 tb/tb_actor_token_fifo.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/actor_token_fifo_pkg.sv
// -----------------------------------------------------------------------------
// actor_token_fifo_pkg
// Shared constants and helpers for the actor token FIFO.
//   COUNT_W        : width of the dataflow token-count fields (In_COUNT/Out_COUNT)
//   DEFAULT_WIDTH  : default token data width
//   DEFAULT_DEPTH  : default token capacity (power of two, >= 2)
//   clog2()        : ceiling log2, used to size pointers and the occupancy counter
// -----------------------------------------------------------------------------
package actor_token_fifo_pkg;

  localparam int COUNT_W       = 16;
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(16) = 4, clog2(17) = 5.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage : actor_token_fifo_pkg

// File: rtl/actor_token_fifo_ram.sv
// -----------------------------------------------------------------------------
// actor_token_fifo_ram
// Token storage for actor_token_fifo: DEPTH x WIDTH array with a synchronous
// write port and an asynchronous (combinational) read port. Contents are not
// reset; the owning FIFO only ever reads locations it has written since reset.
// Ports:
//   clk_i    : clock
//   we_i     : write enable, write happens at the rising edge
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data, follows raddr_i combinationally
// -----------------------------------------------------------------------------
module actor_token_fifo_ram
  import actor_token_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : actor_token_fifo_ram

// File: rtl/actor_token_fifo.sv
// -----------------------------------------------------------------------------
// actor_token_fifo
// Single-clock token FIFO sitting between a dataflow producer output port and a
// consumer input port.
//
// Handshake (both sides): a transfer happens at a rising edge iff the offering
// side's SEND and the accepting side's RDY/ACK term are both high in that
// cycle. On the input side In_RDY depends only on registered state and RESET,
// so the producer can gate In_SEND with it; In_ACK = In_SEND & In_RDY reports
// the accepted token in the same cycle. On the output side Out_SEND means a
// head token is present on Out_DATA; the consumer pulses Out_ACK to take it.
// Offers made without the matching ready term are dropped and latched into the
// sticky Ovf_ERR / Udf_ERR flags.
//
// Ports:
//   CLK, RESET         : clock, synchronous active-high reset
//   In_DATA/In_SEND    : producer token and offer strobe
//   In_COUNT           : producer tokens-per-firing (not used by the FIFO)
//   In_RDY/In_ACK      : space available / token accepted this cycle
//   Out_DATA/Out_SEND  : head token (0 when empty) / FIFO not empty
//   Out_COUNT          : tokens held, zero-extended to COUNT_W
//   Out_ACK            : consumer takes the head token
//   Ovf_ERR/Udf_ERR    : sticky overflow / underflow flags
// -----------------------------------------------------------------------------
module actor_token_fifo
  import actor_token_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [WIDTH-1:0]   In_DATA,
  input  logic               In_SEND,
  input  logic [COUNT_W-1:0] In_COUNT,
  output logic               In_RDY,
  output logic               In_ACK,
  output logic [WIDTH-1:0]   Out_DATA,
  output logic               Out_SEND,
  output logic [COUNT_W-1:0] Out_COUNT,
  input  logic               Out_ACK,
  output logic               Ovf_ERR,
  output logic               Udf_ERR
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("actor_token_fifo: DEPTH must be a power of two and >= 2");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q,    occ_d;
  logic             ovf_q,    ovf_d;
  logic             udf_q,    udf_d;

  logic             not_full;
  logic             not_empty;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] ram_rdata;

  // The token-count field is carried for protocol completeness only.
  logic unused_in_count;
  assign unused_in_count = ^In_COUNT;

  // ---------------------------------------------------------------------------
  // Handshake terms. Both come from registered occupancy, so In_RDY has no
  // path from Out_ACK: a pop while full frees the slot only at the next edge.
  // ---------------------------------------------------------------------------
  assign not_full  = (occ_q < FULL_OCC);
  assign not_empty = (occ_q != '0);

  assign In_RDY   = not_full & ~RESET;
  assign push     = In_SEND & In_RDY;
  assign In_ACK   = push;

  // RESET also masks pop so that the reset edge cannot move the read pointer;
  // the reset branch below overrides everything anyway.
  assign pop      = Out_ACK & not_empty & ~RESET;

  assign Out_SEND  = not_empty;
  assign Out_DATA  = not_empty ? ram_rdata : '0;
  assign Out_COUNT = COUNT_W'(occ_q);
  assign Ovf_ERR   = ovf_q;
  assign Udf_ERR   = udf_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    // Pointers are exactly log2(DEPTH) bits, so +1 wraps modulo DEPTH.
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // Simultaneous push and pop leaves occupancy unchanged.
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase

    if (In_SEND && !In_RDY) begin
      ovf_d = 1'b1;
    end
    if (Out_ACK && !not_empty) begin
      udf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage. push is already gated by RESET through In_RDY, so a token offered
  // in the reset cycle is never written.
  // ---------------------------------------------------------------------------
  actor_token_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (In_DATA),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

endmodule : actor_token_fifo

// File: tb/tb_actor_token_fifo.sv
module tb_actor_token_fifo;
  import actor_token_fifo_pkg::*;

  localparam int W     = 8;
  localparam int DEPTH = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic               CLK = 1'b0;
  logic               RESET = 1'b1;
  logic [W-1:0]       In_DATA = '0;
  logic               In_SEND = 1'b0;
  logic [COUNT_W-1:0] In_COUNT = 16'd1;
  logic               In_RDY;
  logic               In_ACK;
  logic [W-1:0]       Out_DATA;
  logic               Out_SEND;
  logic [COUNT_W-1:0] Out_COUNT;
  logic               Out_ACK = 1'b0;
  logic               Ovf_ERR;
  logic               Udf_ERR;

  always #5 CLK = ~CLK;

  actor_token_fifo #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .In_DATA   (In_DATA),
    .In_SEND   (In_SEND),
    .In_COUNT  (In_COUNT),
    .In_RDY    (In_RDY),
    .In_ACK    (In_ACK),
    .Out_DATA  (Out_DATA),
    .Out_SEND  (Out_SEND),
    .Out_COUNT (Out_COUNT),
    .Out_ACK   (Out_ACK),
    .Ovf_ERR   (Ovf_ERR),
    .Udf_ERR   (Udf_ERR)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state: expected tokens in order, plus a reference model of the
  // occupancy and sticky flags.
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int           m_occ  = 0;
  logic         m_ovf  = 1'b0;
  logic         m_udf  = 1'b0;
  int           errors = 0;
  int           checks = 0;

  // ---------------------------------------------------------------------------
  // Driver tasks. Inputs are driven #1 after a rising edge; tick() advances
  // one edge, updates the model from the inputs that were present before the
  // edge, then returns #1 after the edge with strobes released.
  // ---------------------------------------------------------------------------
  task automatic drive(input logic send, input logic [W-1:0] data, input logic ack);
    In_SEND = send;
    In_DATA = data;
    Out_ACK = ack;
    #1;
  endtask

  task automatic tick();
    logic         do_push;
    logic         do_pop;
    logic         ovf_ev;
    logic         udf_ev;
    logic [W-1:0] d;
    do_push = !RESET && In_SEND && (m_occ < DEPTH);
    do_pop  = !RESET && Out_ACK && (m_occ > 0);
    ovf_ev  = In_SEND && !(m_occ < DEPTH);
    udf_ev  = Out_ACK && (m_occ == 0);
    d       = In_DATA;
    @(posedge CLK);
    if (RESET) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (ovf_ev) m_ovf = 1'b1;
      if (udf_ev) m_udf = 1'b1;
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(d);
    end
    m_occ = exp_q.size();
    #1;
    In_SEND = 1'b0;
    Out_ACK = 1'b0;
  endtask

  task automatic pulse_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    RESET = 1'b1;
    drive(1'b1, 8'h5A, 1'b1);
    checks++; if (In_RDY !== 1'b0) begin errors++; $display("FAIL reset_in_rdy: got %b expected 0", In_RDY); end
    checks++; if (In_ACK !== 1'b0) begin errors++; $display("FAIL reset_in_ack: got %b expected 0", In_ACK); end
    tick();
    RESET = 1'b0;
    #1;
    checks++; if (Out_SEND !== 1'b0) begin errors++; $display("FAIL reset_out_send: got %b expected 0", Out_SEND); end
    checks++; if (Out_COUNT !== 16'd0) begin errors++; $display("FAIL reset_out_count: got %0d expected 0", Out_COUNT); end
    checks++; if (Out_DATA !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %0h expected 0", Out_DATA); end
    checks++; if (Ovf_ERR !== 1'b0 || Udf_ERR !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf=%b udf=%b expected 0/0", Ovf_ERR, Udf_ERR); end
    checks++; if (In_RDY !== 1'b1) begin errors++; $display("FAIL reset_first_rdy: got %b expected 1", In_RDY); end
  endtask

  task automatic test_push3();
    logic [W-1:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vals[i], 1'b0);
      checks++; if (In_ACK !== 1'b1) begin errors++; $display("FAIL push3_ack[%0d]: got %b expected 1", i, In_ACK); end
      tick();
      checks++; if (Out_COUNT !== 16'(i + 1)) begin errors++; $display("FAIL push3_count[%0d]: got %0d expected %0d", i, Out_COUNT, i + 1); end
      checks++; if (Out_DATA !== 8'h11) begin errors++; $display("FAIL push3_head[%0d]: got %0h expected 11", i, Out_DATA); end
    end
    // Drain through the scoreboard.
    while (m_occ > 0) begin
      drive(1'b0, '0, 1'b1);
      checks++; if (Out_DATA !== exp_q[0]) begin errors++; $display("FAIL push3_drain: got %0h expected %0h", Out_DATA, exp_q[0]); end
      tick();
    end
    checks++; if (Out_SEND !== 1'b0) begin errors++; $display("FAIL push3_empty: got %b expected 0", Out_SEND); end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      checks++; if (In_ACK !== 1'b1) begin errors++; $display("FAIL fill_ack[%0d]: got %b expected 1", i, In_ACK); end
      tick();
    end
    checks++; if (In_RDY !== 1'b0) begin errors++; $display("FAIL full_rdy: got %b expected 0", In_RDY); end
    checks++; if (Out_COUNT !== 16'd16) begin errors++; $display("FAIL full_count: got %0d expected 16", Out_COUNT); end
    drive(1'b1, 8'hAA, 1'b0);
    checks++; if (In_ACK !== 1'b0) begin errors++; $display("FAIL ovf_ack: got %b expected 0", In_ACK); end
    tick();
    checks++; if (Ovf_ERR !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", Ovf_ERR); end
    checks++; if (Out_COUNT !== 16'd16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", Out_COUNT); end
    // Pop alone while full: ready must not rise in the same cycle.
    drive(1'b0, '0, 1'b1);
    checks++; if (In_RDY !== 1'b0) begin errors++; $display("FAIL full_pop_same_cycle_rdy: got %b expected 0", In_RDY); end
    tick();
    checks++; if (Out_DATA !== 8'h01) begin errors++; $display("FAIL full_pop_head: got %0h expected 01", Out_DATA); end
    checks++; if (Out_COUNT !== 16'd15) begin errors++; $display("FAIL full_pop_count: got %0d expected 15", Out_COUNT); end
    checks++; if (In_RDY !== 1'b1) begin errors++; $display("FAIL full_pop_next_rdy: got %b expected 1", In_RDY); end
    drive(1'b1, 8'hBB, 1'b0);
    checks++; if (In_ACK !== 1'b1) begin errors++; $display("FAIL push_bb_ack: got %b expected 1", In_ACK); end
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      logic [W-1:0] want;
      want = (i < 15) ? 8'(i + 1) : 8'hBB;
      drive(1'b0, '0, 1'b1);
      checks++; if (Out_DATA !== want || Out_DATA !== exp_q[0]) begin errors++; $display("FAIL full_drain[%0d]: got %0h expected %0h", i, Out_DATA, want); end
      tick();
    end
    checks++; if (Out_COUNT !== 16'd0) begin errors++; $display("FAIL full_drain_count: got %0d expected 0", Out_COUNT); end
    pulse_reset();
    checks++; if (Ovf_ERR !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", Ovf_ERR); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d;
    d = 8'h40;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, d, 1'b0);
      tick();
      d = d + 8'd1;
    end
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, d, 1'b1);
      checks++; if (In_ACK !== 1'b1) begin errors++; $display("FAIL b2b_ack[%0d]: got %b expected 1", i, In_ACK); end
      checks++; if (Out_DATA !== exp_q[0] || Out_DATA !== 8'(8'h40 + i)) begin errors++; $display("FAIL b2b_head[%0d]: got %0h expected %0h", i, Out_DATA, 8'(8'h40 + i)); end
      tick();
      checks++; if (Out_COUNT !== 16'd4) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected 4", i, Out_COUNT); end
      d = d + 8'd1;
    end
    while (m_occ > 0) begin
      drive(1'b0, '0, 1'b1);
      checks++; if (Out_DATA !== exp_q[0]) begin errors++; $display("FAIL b2b_drain: got %0h expected %0h", Out_DATA, exp_q[0]); end
      tick();
    end
  endtask

  task automatic test_underflow();
    drive(1'b0, '0, 1'b1);
    tick();
    checks++; if (Udf_ERR !== 1'b1) begin errors++; $display("FAIL udf_flag: got %b expected 1", Udf_ERR); end
    checks++; if (Out_COUNT !== 16'd0 || Out_SEND !== 1'b0) begin errors++; $display("FAIL udf_count: got %0d/%b expected 0/0", Out_COUNT, Out_SEND); end
    // Pointer must not have moved: the next token in is the next token out.
    drive(1'b1, 8'h7E, 1'b0);
    tick();
    checks++; if (Out_DATA !== 8'h7E || Out_COUNT !== 16'd1) begin errors++; $display("FAIL udf_ptr: got %0h/%0d expected 7e/1", Out_DATA, Out_COUNT); end
    pulse_reset();
    checks++; if (Udf_ERR !== 1'b0) begin errors++; $display("FAIL udf_clear: got %b expected 0", Udf_ERR); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(8'hC0 + i), 1'b0);
      tick();
    end
    checks++; if (Out_COUNT !== 16'd5) begin errors++; $display("FAIL mid_pre_count: got %0d expected 5", Out_COUNT); end
    RESET = 1'b1;
    drive(1'b1, 8'hEE, 1'b1);
    checks++; if (In_ACK !== 1'b0) begin errors++; $display("FAIL mid_ack: got %b expected 0", In_ACK); end
    tick();
    RESET = 1'b0;
    #1;
    checks++; if (Out_SEND !== 1'b0 || Out_COUNT !== 16'd0) begin errors++; $display("FAIL mid_cleared: got send=%b count=%0d expected 0/0", Out_SEND, Out_COUNT); end
    checks++; if (Out_DATA !== 8'h00) begin errors++; $display("FAIL mid_data: got %0h expected 0", Out_DATA); end
    checks++; if (In_RDY !== 1'b1) begin errors++; $display("FAIL mid_rdy: got %b expected 1", In_RDY); end
    drive(1'b1, 8'h3C, 1'b0);
    tick();
    checks++; if (Out_DATA !== 8'h3C || Out_SEND !== 1'b1) begin errors++; $display("FAIL mid_latency: got %0h/%b expected 3c/1", Out_DATA, Out_SEND); end
    pulse_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      int p_send;
      int p_ack;
      logic send;
      logic ack;
      // Bias phases toward filling then draining so both full and empty occur.
      p_send = ((i / 50) % 2 == 0) ? 80 : 25;
      p_ack  = ((i / 50) % 2 == 0) ? 25 : 80;
      send = ($urandom_range(0, 99) < p_send);
      ack  = ($urandom_range(0, 99) < p_ack);
      drive(send, 8'($urandom_range(0, 255)), ack);
      checks++; if (In_RDY !== (m_occ < DEPTH)) begin errors++; $display("FAIL rnd_rdy[%0d]: got %b expected %b", i, In_RDY, (m_occ < DEPTH)); end
      checks++; if (In_ACK !== (send && (m_occ < DEPTH))) begin errors++; $display("FAIL rnd_ack[%0d]: got %b expected %b", i, In_ACK, (send && (m_occ < DEPTH))); end
      checks++; if (Out_COUNT !== 16'(m_occ)) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, Out_COUNT, m_occ); end
      if (m_occ > 0) begin
        checks++; if (Out_DATA !== exp_q[0]) begin errors++; $display("FAIL rnd_head[%0d]: got %0h expected %0h", i, Out_DATA, exp_q[0]); end
      end else begin
        checks++; if (Out_DATA !== 8'h00 || Out_SEND !== 1'b0) begin errors++; $display("FAIL rnd_empty[%0d]: got %0h/%b expected 0/0", i, Out_DATA, Out_SEND); end
      end
      tick();
    end
    checks++; if (Ovf_ERR !== m_ovf) begin errors++; $display("FAIL rnd_ovf: got %b expected %b", Ovf_ERR, m_ovf); end
    checks++; if (Udf_ERR !== m_udf) begin errors++; $display("FAIL rnd_udf: got %b expected %b", Udf_ERR, m_udf); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    @(posedge CLK);
    #1;
    test_reset();
    test_push3();
    test_full();
    test_back_to_back();
    test_underflow();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_actor_token_fifo
